// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch command controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'b00,
    CMD_RUNSTOP = 2'b01,
    CMD_CLEAR   = 2'b10,
    CMD_LAP     = 2'b11
  } cmd_e;

  localparam logic [7:0]  UART_RUN_BYTE      = 8'h52;
  localparam logic [7:0]  UART_CLEAR_BYTE    = 8'h43;
  localparam logic [7:0]  UART_LAP_BYTE      = 8'h4C;
  localparam int unsigned LAP_HOLD_TICKS_DEF = 300;
  localparam int unsigned TICK_W_DEF         = 9;

  localparam int BTN_W       = 3;
  localparam int BTN_RUNSTOP = 0;
  localparam int BTN_CLEAR   = 1;
  localparam int BTN_LAP     = 2;

  function automatic cmd_e uart_decode(
    input logic       valid,
    input logic [7:0] data,
    input logic [7:0] run_byte,
    input logic [7:0] clear_byte,
    input logic [7:0] lap_byte
  );
    cmd_e cmd;
    cmd = CMD_NONE;
    if (valid) begin
      if (data == run_byte)        cmd = CMD_RUNSTOP;
      else if (data == clear_byte) cmd = CMD_CLEAR;
      else if (data == lap_byte)   cmd = CMD_LAP;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector for debounced button levels; one press
// pulse per rising edge, delayed one clock.
module btn_edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= '0;
      press <= '0;
    end else begin
      prev  <= level;
      press <= level & ~prev;
    end
  end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch control: merges buttons and UART commands into one stream and
// drives run enable, clear pulse and lap display hold.
//
//   state | meaning
//   STOP  | counting halted, outputs idle
//   RUN   | datapath counting
//   LAP   | counting continues, display frozen until lap/runstop/timeout
//   CLEAR | single-cycle clear pulse, then STOP
module stopwatch_cmd_ctrl #(
  parameter logic [7:0]  CMD_RUN        = stopwatch_pkg::UART_RUN_BYTE,
  parameter logic [7:0]  CMD_CLEAR      = stopwatch_pkg::UART_CLEAR_BYTE,
  parameter logic [7:0]  CMD_LAP        = stopwatch_pkg::UART_LAP_BYTE,
  parameter int unsigned LAP_HOLD_TICKS = stopwatch_pkg::LAP_HOLD_TICKS_DEF,
  parameter int unsigned TICK_W         = stopwatch_pkg::TICK_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_runstop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic       i_tick_100hz,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_lap_hold,
  output logic [1:0] o_state,
  output logic       o_cmd_ack
);
  import stopwatch_pkg::*;

  localparam logic [TICK_W-1:0] HOLD_LIMIT = TICK_W'(LAP_HOLD_TICKS);
  localparam bit                HOLD_EN    = (LAP_HOLD_TICKS != 0);

  logic [BTN_W-1:0]  btn_press;
  cmd_e              rx_cmd;
  cmd_e              pend_cmd;
  cmd_e              pend_nxt;
  cmd_e              exec_cmd;
  logic              exec_uart;
  logic              rx_taken;
  state_e            state;
  state_e            state_nxt;
  logic [TICK_W-1:0] hold_cnt;
  logic [TICK_W-1:0] hold_nxt;

  btn_edge_detect #(.WIDTH(BTN_W)) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({btn_lap, btn_clear, btn_runstop}),
    .press (btn_press)
  );

  assign rx_cmd = uart_decode(rx_valid, rx_data, CMD_RUN, CMD_CLEAR, CMD_LAP);

  // Nothing executes during CLEAR; a UART command that does not run this
  // cycle lands in the pending slot, replacing whatever was there.
  always_comb begin
    exec_cmd  = CMD_NONE;
    exec_uart = 1'b0;
    rx_taken  = 1'b0;
    pend_nxt  = pend_cmd;
    if (state != ST_CLEAR) begin
      if (btn_press[BTN_RUNSTOP]) begin
        exec_cmd = CMD_RUNSTOP;
      end else if (btn_press[BTN_CLEAR]) begin
        exec_cmd = stopwatch_pkg::CMD_CLEAR;
      end else if (btn_press[BTN_LAP]) begin
        exec_cmd = stopwatch_pkg::CMD_LAP;
      end else if (pend_cmd != CMD_NONE) begin
        exec_cmd  = pend_cmd;
        exec_uart = 1'b1;
        pend_nxt  = CMD_NONE;
      end else if (rx_cmd != CMD_NONE) begin
        exec_cmd  = rx_cmd;
        exec_uart = 1'b1;
        rx_taken  = 1'b1;
      end
    end
    if (rx_cmd != CMD_NONE && !rx_taken) begin
      pend_nxt = rx_cmd;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_STOP: begin
        if (exec_cmd == CMD_RUNSTOP)                  state_nxt = ST_RUN;
        else if (exec_cmd == stopwatch_pkg::CMD_CLEAR) state_nxt = ST_CLEAR;
      end
      ST_RUN: begin
        if (exec_cmd == CMD_RUNSTOP) begin
          state_nxt = ST_STOP;
        end else if (exec_cmd == stopwatch_pkg::CMD_LAP) begin
          state_nxt = ST_LAP;
          hold_nxt  = '0;
        end
      end
      ST_LAP: begin
        if (exec_cmd == CMD_RUNSTOP) begin
          state_nxt = ST_STOP;
        end else if (exec_cmd == stopwatch_pkg::CMD_LAP) begin
          state_nxt = ST_RUN;
        end else if (HOLD_EN && i_tick_100hz) begin
          if (hold_cnt < HOLD_LIMIT) hold_nxt = hold_cnt + 1'b1;
          if (hold_cnt >= HOLD_LIMIT - 1'b1) state_nxt = ST_RUN;
        end
      end
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_STOP;
      pend_cmd   <= CMD_NONE;
      hold_cnt   <= '0;
      o_runstop  <= 1'b0;
      o_clear    <= 1'b0;
      o_lap_hold <= 1'b0;
      o_cmd_ack  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_cmd   <= pend_nxt;
      hold_cnt   <= hold_nxt;
      o_runstop  <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
      o_clear    <= (state_nxt == ST_CLEAR);
      o_lap_hold <= (state_nxt == ST_LAP);
      o_cmd_ack  <= exec_uart;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Self-checking bench for stopwatch_cmd_ctrl: vector table plus sequences
// for contention, pending overwrite, lap timeout and async reset.
module tb_stopwatch_cmd_ctrl;

  localparam logic [5:0] E_STOP = 6'b000000;
  localparam logic [5:0] E_RUN  = 6'b100010;
  localparam logic [5:0] E_LAP  = 6'b101110;
  localparam logic [5:0] E_CLR  = 6'b010100;
  localparam logic [5:0] ACK    = 6'b000001;

  typedef struct {
    string      nm;
    logic [2:0] btn;
    logic       tick;
    logic       rxv;
    logic [7:0] rxd;
    logic [5:0] exp;
    int         reps;
  } vec_t;

  typedef struct {
    string      nm;
    logic [5:0] exp;
  } sb_t;

  logic       clk;
  logic       rst;
  logic       btn_runstop, btn_clear, btn_lap;
  logic       i_tick_100hz;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       o_runstop, o_clear, o_lap_hold, o_cmd_ack;
  logic [1:0] o_state;
  logic       n_runstop, n_clear, n_lap_hold, n_cmd_ack;
  logic [1:0] n_state;
  logic [5:0] dut_vec, nh_vec;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];

  stopwatch_cmd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn_runstop  (btn_runstop),
    .btn_clear    (btn_clear),
    .btn_lap      (btn_lap),
    .i_tick_100hz (i_tick_100hz),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .o_runstop    (o_runstop),
    .o_clear      (o_clear),
    .o_lap_hold   (o_lap_hold),
    .o_state      (o_state),
    .o_cmd_ack    (o_cmd_ack)
  );

  stopwatch_cmd_ctrl #(.LAP_HOLD_TICKS(0)) dut_nohold (
    .clk          (clk),
    .rst          (rst),
    .btn_runstop  (btn_runstop),
    .btn_clear    (btn_clear),
    .btn_lap      (btn_lap),
    .i_tick_100hz (i_tick_100hz),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .o_runstop    (n_runstop),
    .o_clear      (n_clear),
    .o_lap_hold   (n_lap_hold),
    .o_state      (n_state),
    .o_cmd_ack    (n_cmd_ack)
  );

  assign dut_vec = {o_runstop, o_clear, o_lap_hold, o_state, o_cmd_ack};
  assign nh_vec  = {n_runstop, n_clear, n_lap_hold, n_state, n_cmd_ack};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (runstop clear lap_hold state[1:0] ack)", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic [2:0] btn, input logic tick,
                               input logic rxv, input logic [7:0] rxd,
                               input logic [5:0] exp, input int reps);
    vec_t v;
    v.nm = nm; v.btn = btn; v.tick = tick; v.rxv = rxv; v.rxd = rxd;
    v.exp = exp; v.reps = reps;
    return v;
  endfunction

  // btn bits: [0] runstop, [1] clear, [2] lap
  task automatic step(input string nm, input logic [2:0] btn, input logic tick,
                      input logic rxv, input logic [7:0] rxd, input logic [5:0] exp);
    sb_t s;
    @(negedge clk);
    btn_runstop  = btn[0];
    btn_clear    = btn[1];
    btn_lap      = btn[2];
    i_tick_100hz = tick;
    rx_valid     = rxv;
    rx_data      = rxd;
    s.nm = nm; s.exp = exp;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    check(s.nm, dut_vec, s.exp);
    rx_valid     = 1'b0;
    i_tick_100hz = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    btn_runstop = 0; btn_clear = 0; btn_lap = 0;
    i_tick_100hz = 0; rx_valid = 0; rx_data = 8'h00;

    vecs.push_back(mkv("idle",          3'b000, 0, 0, 8'h00, E_STOP,       2));
    vecs.push_back(mkv("rs_edge",       3'b001, 0, 0, 8'h00, E_STOP,       1));
    vecs.push_back(mkv("rs_held_run",   3'b001, 0, 0, 8'h00, E_RUN,       49));
    vecs.push_back(mkv("rs_release",    3'b000, 0, 0, 8'h00, E_RUN,        2));
    vecs.push_back(mkv("rs2_edge",      3'b001, 0, 0, 8'h00, E_RUN,        1));
    vecs.push_back(mkv("rs2_stop",      3'b001, 0, 0, 8'h00, E_STOP,       2));
    vecs.push_back(mkv("rs2_release",   3'b000, 0, 0, 8'h00, E_STOP,       1));
    vecs.push_back(mkv("uart_C_stop",   3'b000, 0, 1, 8'h43, E_CLR | ACK,  1));
    vecs.push_back(mkv("clear_end",     3'b000, 0, 0, 8'h00, E_STOP,       2));
    vecs.push_back(mkv("uart_R_run",    3'b000, 0, 1, 8'h52, E_RUN | ACK,  1));
    vecs.push_back(mkv("run_idle",      3'b000, 0, 0, 8'h00, E_RUN,        1));
    vecs.push_back(mkv("uart_C_in_run", 3'b000, 0, 1, 8'h43, E_RUN | ACK,  1));
    vecs.push_back(mkv("run_idle2",     3'b000, 0, 0, 8'h00, E_RUN,        1));
    vecs.push_back(mkv("uart_bad_A",    3'b000, 0, 1, 8'h41, E_RUN,        1));
    vecs.push_back(mkv("uart_L_lap",    3'b000, 0, 1, 8'h4C, E_LAP | ACK,  1));
    vecs.push_back(mkv("uart_L_unlap",  3'b000, 0, 1, 8'h4C, E_RUN | ACK,  1));
    vecs.push_back(mkv("btn_clr_edge",  3'b010, 0, 0, 8'h00, E_RUN,        1));
    vecs.push_back(mkv("btn_clr_run",   3'b000, 0, 0, 8'h00, E_RUN,        1));
    vecs.push_back(mkv("uart_R_stop",   3'b000, 0, 1, 8'h52, E_STOP | ACK, 1));
    vecs.push_back(mkv("btn_lap_edge",  3'b100, 0, 0, 8'h00, E_STOP,       1));
    vecs.push_back(mkv("btn_lap_stop",  3'b000, 0, 0, 8'h00, E_STOP,       1));
    vecs.push_back(mkv("uart_L_stop",   3'b000, 0, 1, 8'h4C, E_STOP | ACK, 1));

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec, E_STOP);
    check("reset_state_nohold", nh_vec, E_STOP);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].nm, vecs[i].btn, vecs[i].tick, vecs[i].rxv, vecs[i].rxd, vecs[i].exp);
      end
    end

    // button and UART runstop reach the arbiter together
    step("cont_edge",    3'b001, 0, 0, 8'h00, E_STOP);
    step("cont_btn_win", 3'b001, 0, 1, 8'h52, E_RUN);
    step("cont_pending", 3'b000, 0, 0, 8'h00, E_STOP | ACK);
    step("cont_after",   3'b000, 0, 0, 8'h00, E_STOP);

    // pending 'L' overwritten by 'R' while a second button holds the slot
    step("ovw_rs_edge",  3'b001, 0, 0, 8'h00, E_STOP);
    step("ovw_L_lost",   3'b011, 0, 1, 8'h4C, E_RUN);
    step("ovw_R_lost",   3'b010, 0, 1, 8'h52, E_RUN);
    step("ovw_R_exec",   3'b000, 0, 0, 8'h00, E_STOP | ACK);
    step("ovw_L_gone",   3'b000, 0, 0, 8'h00, E_STOP);

    // UART arriving during CLEAR waits in pending
    step("clr_C",        3'b000, 0, 1, 8'h43, E_CLR | ACK);
    step("clr_R_pend",   3'b000, 0, 1, 8'h52, E_STOP);
    step("clr_R_exec",   3'b000, 0, 0, 8'h00, E_RUN | ACK);
    step("clr_R_stop",   3'b000, 0, 1, 8'h52, E_STOP | ACK);

    // lap hold timeout
    step("lap_run",      3'b000, 0, 1, 8'h52, E_RUN | ACK);
    step("lap_enter",    3'b000, 0, 1, 8'h4C, E_LAP | ACK);
    for (int t = 1; t < 300; t++) step("lap_hold_tick", 3'b000, 1, 0, 8'h00, E_LAP);
    step("lap_tick300",  3'b000, 1, 0, 8'h00, E_RUN);
    check("nohold_at_300", nh_vec, E_LAP);
    for (int t = 300; t < 1000; t++) step("run_after_lap", 3'b000, 1, 0, 8'h00, E_RUN);
    check("nohold_at_1000", nh_vec, E_LAP);
    step("lap_reenter",  3'b000, 0, 1, 8'h4C, E_LAP | ACK);
    check("nohold_unlap", nh_vec, E_RUN | ACK);

    // hold counter restarts on each entry into LAP
    for (int t = 0; t < 200; t++) step("lap_first200", 3'b000, 1, 0, 8'h00, E_LAP);
    step("lap_exit",     3'b000, 0, 1, 8'h4C, E_RUN | ACK);
    step("lap_again",    3'b000, 0, 1, 8'h4C, E_LAP | ACK);
    for (int t = 0; t < 200; t++) step("lap_second200", 3'b000, 1, 0, 8'h00, E_LAP);

    // asynchronous reset in the middle of LAP
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_lap", dut_vec, E_STOP);
    check("async_reset_nohold", nh_vec, E_STOP);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_edge", 3'b001, 0, 0, 8'h00, E_STOP);
    step("post_rst_run",  3'b001, 0, 0, 8'h00, E_RUN);
    step("post_rst_rel",  3'b000, 0, 0, 8'h00, E_RUN);

    // runstop out of LAP drops the hold flag
    step("lap3_enter",    3'b000, 0, 1, 8'h4C, E_LAP | ACK);
    step("lap3_rs_edge",  3'b001, 0, 0, 8'h00, E_LAP);
    step("lap3_rs_stop",  3'b000, 0, 0, 8'h00, E_STOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_cmd_ctrl.md
Name: stopwatch_cmd_ctrl

Overview:
Control unit that sequences the stopwatch datapath (run/stop, clear, lap freeze).
- Merges three board buttons with single-byte UART commands into one ordered command stream.
- Drives the run enable and clear pulse of the stopwatch datapath, plus a lap-hold flag that freezes the FND time display while counting continues.
- Sits between the button debouncers / UART RX and stopwatch_dp / display controller.

Parameters:
CMD_RUN, 8'h52, UART byte 'R' = run/stop toggle
CMD_CLEAR, 8'h43, UART byte 'C' = clear
CMD_LAP, 8'h4C, UART byte 'L' = lap toggle
LAP_HOLD_TICKS, 300, i_tick_100hz pulses before lap hold auto-releases (300 = 3 s); 0 = never auto-release
TICK_W, 9, width of lap hold counter; must satisfy 2^TICK_W > LAP_HOLD_TICKS

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
btn_runstop  in  1  debounced level, high while pressed
btn_clear  in  1  debounced level
btn_lap  in  1  debounced level
i_tick_100hz  in  1  one-cycle strobe every 10 ms
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received UART byte
o_runstop  out  1  datapath count enable (level)
o_clear  out  1  one-cycle datapath clear pulse
o_lap_hold  out  1  display freeze request (level)
o_state  out  2  current FSM state code
o_cmd_ack  out  1  one-cycle pulse per UART command executed

Behaviour:
- Reset (rst=0, async): state=STOP, o_runstop=0, o_clear=0, o_lap_hold=0, o_cmd_ack=0, edge registers=0, pending=empty, hold counter=0.
- Button edge detect: registered previous level; press event = level 1 & prev 0, one cycle after the rising edge. Holding a button gives exactly one event.
- UART decode: rx_valid with rx_data ∈ {CMD_RUN, CMD_CLEAR, CMD_LAP} gives a command. Any other byte is ignored, no ack.
- Arbitration, one command executed per cycle; priority order:
  1. button runstop
  2. button clear
  3. button lap
  4. pending UART
  5. new UART
- Lower-priority button events in the same cycle are dropped.
- A UART command that loses arbitration is stored in a 1-entry pending register. If pending is full and another UART command arrives, the new one overwrites it (last wins, earlier one is not acked).
- o_cmd_ack pulses in the cycle the UART command is executed, even if the command has no effect in the current state.
- States (o_state code):
  - STOP (00): runstop -> RUN. clear -> CLEAR. lap ignored.
  - RUN (01): runstop -> STOP. lap -> LAP (load hold counter = 0). clear ignored.
  - LAP (11): o_runstop stays 1 and o_lap_hold=1.
    - lap -> RUN.
    - runstop -> STOP, with o_lap_hold cleared.
    - clear ignored.
    - If LAP_HOLD_TICKS≠0, counter increments on i_tick_100hz; on reaching LAP_HOLD_TICKS -> RUN.
  - CLEAR (10): lasts exactly one cycle with o_clear=1, then -> STOP. Commands arriving in CLEAR: buttons dropped, UART goes to pending.
- Outputs are registered, Moore:
  - o_runstop = (state==RUN || state==LAP)
  - o_lap_hold = (state==LAP)
  - o_clear = (state==CLEAR)
- Latency: button rising edge -> output change after 2 clk. UART rx_valid -> output change after 1 clk when uncontended.
- Hold counter saturates at LAP_HOLD_TICKS and resets on every entry into LAP.
- Reset mid-LAP or mid-CLEAR: immediate return to STOP, no clear pulse completes.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state codes ST_STOP/ST_RUN/ST_CLEAR/ST_LAP
  - command encoding CMD_NONE/CMD_RUNSTOP/CMD_CLEAR/CMD_LAP (2-bit)
  - default UART byte constants
- One sub-module, btn_edge_detect (parameterised width 3), instanced once for the three buttons.
- FSM, arbiter, pending register and hold counter stay in the top module.

Test Plan:
- Reset then btn_runstop pulse held 50 cycles -> o_runstop=1 from 2 cycles after the edge, o_state=01, a single event only. Second press -> o_runstop=0, o_state=00.
- In STOP, rx_valid with rx_data=8'h43 -> o_clear high for exactly 1 cycle, o_cmd_ack=1 in the same cycle, then o_state=00.
- In RUN, btn_lap -> o_lap_hold=1 with o_runstop=1. Apply 300 i_tick_100hz strobes -> o_lap_hold=0 and o_state=01 one cycle after the 300th tick. With LAP_HOLD_TICKS=0, hold persists after 1000 ticks.
- btn_runstop edge and rx_data=8'h52 in the same cycle from STOP -> button executes (RUN). Next cycle UART executes (STOP) with o_cmd_ack pulse.
- In RUN, rx_data=8'h43 -> no state change, o_cmd_ack=1. Then rx_data=8'h41 -> no ack, no change.
- Assert rst low during LAP, asynchronously between clock edges -> all outputs 0 immediately, o_state=00. After release, next runstop works normally.
